// File: rtl/rv_core_pkg.sv
// Shared RV core definitions: default widths, register-file FSM states and the
// hardwired-zero register index.
package rv_core_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned REG_ZERO     = 0;

    // Register file lifecycle: zeroing sweep after reset, then normal operation.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard for the integer register file.
// One bit per register: set by an issue-time claim, cleared by writeback;
// a claim beats a writeback to the same register in the same cycle.
// Ports:
//   clock, reset_n   clock and synchronous active-low reset
//   run_i            block is out of its zeroing sweep (claims/writes honoured)
//   wr_en_i/addr_i   writeback clearing a pending bit
//   claim_en_i/addr_i issue-time reservation setting a pending bit
//   rd_addr_i        packed read addresses, port k at [k*AW +: AW]
//   rd_pend_o_c      combinational pending bit of each port's register
module regfile_scoreboard
    import rv_core_pkg::*;
#(
    parameter  int unsigned NUM_REGS = NREG_DEFAULT,
    parameter  int unsigned NUM_READ = 2,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run_i,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic                     claim_en_i,
    input  logic [AW-1:0]            claim_addr_i,
    input  logic [NUM_READ*AW-1:0]   rd_addr_i,
    output logic [NUM_READ-1:0]      rd_pend_o_c
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear on writeback first so a same-cycle claim overrides it.
    always_comb begin
        pending_d = pending_q;
        if (run_i) begin
            if (wr_en_i && (wr_addr_i != AW'(REG_ZERO))) begin
                pending_d[wr_addr_i] = 1'b0;
            end
            if (claim_en_i && (claim_addr_i != AW'(REG_ZERO))) begin
                pending_d[claim_addr_i] = 1'b1;
            end
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Per-port lookup of the pre-edge pending bit.
    always_comb begin
        rd_pend_o_c = '0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            rd_pend_o_c[k] = pending_q[rd_addr_i[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with post-reset zeroing sweep,
// optional write-to-read bypass and a RAW-hazard pending scoreboard.
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   init_done             high once the zeroing sweep has finished
//   rd_addr/rd_data       packed read ports (combinational, 0-cycle)
//   rd_busy               read register has an outstanding claim
//   wr_en/wr_addr/wr_data writeback port (clocked)
//   claim_en/claim_addr   issue-time destination reservation
module regfile_mp
    import rv_core_pkg::*;
#(
    parameter  int unsigned XLEN     = XLEN_DEFAULT,
    parameter  int unsigned NUM_REGS = NREG_DEFAULT,
    parameter  int unsigned NUM_READ = 2,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    output logic                       init_done,
    input  logic [NUM_READ*AW-1:0]     rd_addr,
    output logic [NUM_READ*XLEN-1:0]   rd_data,
    output logic [NUM_READ-1:0]        rd_busy,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       claim_en,
    input  logic [AW-1:0]              claim_addr
);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [AW-1:0]     cnt_q;
    logic [AW-1:0]     cnt_d;
    logic [XLEN-1:0]   mem_q [NUM_REGS];
    logic              run_c;
    logic              wr_ok_c;
    logic [NUM_READ-1:0] pend_c;
    logic [AW-1:0]     rd_idx_c;

    assign run_c     = (state_q == RUN);
    assign wr_ok_c   = run_c && wr_en && (wr_addr != AW'(REG_ZERO));
    assign init_done = run_c;

    // Sweep FSM: one entry zeroed per cycle, RUN after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NUM_REGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: entry 0 is never written; reads of r0 are forced to zero.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state_q == INIT) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_ok_c) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_READ (NUM_READ)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .run_i        (run_c),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .claim_en_i   (claim_en),
        .claim_addr_i (claim_addr),
        .rd_addr_i    (rd_addr),
        .rd_pend_o_c  (pend_c)
    );

    // Read muxing: zero during sweep and for r0, bypass a matching writeback.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        rd_idx_c = '0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            rd_idx_c = rd_addr[k*AW +: AW];
            if (run_c && (rd_idx_c != AW'(REG_ZERO))) begin
                if ((BYPASS != 0) && wr_en && (wr_addr == rd_idx_c)) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                    rd_busy[k]              = 1'b0;
                end else begin
                    rd_data[k*XLEN +: XLEN] = mem_q[rd_idx_c];
                    rd_busy[k]              = pend_c[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default 32x32 2-port bypassing instance and a
// 16x64 3-port non-bypassing instance, checked against an array model.
module tb_regfile_mp;

    logic        clock;
    logic        t_rst_n;
    int          sel;
    logic        t_wr_en;
    logic [4:0]  t_wr_addr;
    logic [63:0] t_wr_data;
    logic        t_claim_en;
    logic [4:0]  t_claim_addr;
    logic [4:0]  t_ra [3];

    int checks;
    int errors;

    // Instance A: defaults (XLEN 32, 32 regs, 2 ports, bypass on).
    logic        a_rst_n;
    logic        a_init;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_busy;

    // Instance B: XLEN 64, 16 regs, 3 ports, bypass off.
    logic         b_rst_n;
    logic         b_init;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_busy;

    assign a_rst_n   = (sel == 0) ? t_rst_n : 1'b0;
    assign b_rst_n   = (sel == 1) ? t_rst_n : 1'b0;
    assign a_rd_addr = {t_ra[1], t_ra[0]};
    assign b_rd_addr = {t_ra[2][3:0], t_ra[1][3:0], t_ra[0][3:0]};

    regfile_mp dut_a (
        .clock      (clock),
        .reset_n    (a_rst_n),
        .init_done  (a_init),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .rd_busy    (a_busy),
        .wr_en      (t_wr_en),
        .wr_addr    (t_wr_addr),
        .wr_data    (t_wr_data[31:0]),
        .claim_en   (t_claim_en),
        .claim_addr (t_claim_addr)
    );

    regfile_mp #(
        .XLEN     (64),
        .NUM_REGS (16),
        .NUM_READ (3),
        .BYPASS   (0)
    ) dut_b (
        .clock      (clock),
        .reset_n    (b_rst_n),
        .init_done  (b_init),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_busy    (b_busy),
        .wr_en      (t_wr_en),
        .wr_addr    (t_wr_addr[3:0]),
        .wr_data    (t_wr_data),
        .claim_en   (t_claim_en),
        .claim_addr (t_claim_addr[3:0])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: register contents, pending flags, sweep cycles left.
    logic [63:0] m_mem  [32];
    bit          m_pend [32];
    int          m_left;
    int          cfg_nregs;
    int          cfg_nread;
    bit          cfg_byp;
    int          cfg_xlen;

    function automatic logic [63:0] fit(input logic [63:0] d);
        return (cfg_xlen == 32) ? {32'h0, d[31:0]} : d;
    endfunction

    function automatic logic [63:0] exp_data(input int k);
        int a = int'(t_ra[k]) % cfg_nregs;
        if (m_left > 0 || a == 0) return 64'h0;
        if (cfg_byp && t_wr_en && (int'(t_wr_addr) % cfg_nregs) == a) return fit(t_wr_data);
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int k);
        int a = int'(t_ra[k]) % cfg_nregs;
        if (m_left > 0 || a == 0) return 1'b0;
        if (cfg_byp && t_wr_en && (int'(t_wr_addr) % cfg_nregs) == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic obs_init();
        return (sel == 0) ? a_init : b_init;
    endfunction

    function automatic logic [63:0] obs_data(input int k);
        if (sel == 0) return {32'h0, a_rd_data[k*32 +: 32]};
        return b_rd_data[k*64 +: 64];
    endfunction

    function automatic logic obs_busy(input int k);
        return (sel == 0) ? a_busy[k] : b_busy[k];
    endfunction

    task automatic model_edge();
        int wa = int'(t_wr_addr) % cfg_nregs;
        int ca = int'(t_claim_addr) % cfg_nregs;
        if (!t_rst_n) begin
            m_left = cfg_nregs - 1;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) for (int i = 0; i < 32; i++) m_mem[i] = 64'h0;
        end else begin
            if (t_wr_en && wa != 0) begin
                m_mem[wa]  = fit(t_wr_data);
                m_pend[wa] = 1'b0;
            end
            if (t_claim_en && ca != 0) m_pend[ca] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_init"}, 64'(obs_init()), 64'(m_left == 0));
        for (int k = 0; k < cfg_nread; k++) begin
            chk($sformatf("%s_data%0d", tag, k), obs_data(k), exp_data(k));
            chk($sformatf("%s_busy%0d", tag, k), 64'(obs_busy(k)), 64'(exp_busy(k)));
        end
    endtask

    // Check the settled comb outputs, then advance one clock.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic clear_ctl();
        t_wr_en    = 1'b0;
        t_claim_en = 1'b0;
    endtask

    // Count cycles with init_done low until it rises (bounded).
    task automatic sweep(input string tag, input int exp_len);
        int cnt = 0;
        for (int i = 0; i < exp_len + 10; i++) begin
            if (obs_init()) break;
            cnt++;
            step(tag);
            clear_ctl();
        end
        chk({tag, "_len"}, 64'(cnt), 64'(exp_len));
    endtask

    task automatic rand_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            t_wr_en      = 1'($urandom_range(0, 1));
            t_wr_addr    = 5'($urandom_range(0, cfg_nregs - 1));
            t_wr_data    = {$urandom, $urandom};
            t_claim_en   = 1'($urandom_range(0, 1));
            t_claim_addr = ($urandom_range(0, 3) == 0) ? t_wr_addr
                                                       : 5'($urandom_range(0, cfg_nregs - 1));
            for (int k = 0; k < 3; k++) begin
                t_ra[k] = ($urandom_range(0, 2) == 0) ? t_wr_addr
                                                      : 5'($urandom_range(0, cfg_nregs - 1));
            end
            step(tag);
        end
        clear_ctl();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 64'h0;
            m_pend[i] = 1'b0;
        end
        sel = 0; cfg_nregs = 32; cfg_nread = 2; cfg_byp = 1'b1; cfg_xlen = 32;
        m_left = 31;
        t_wr_en = 1'b0; t_wr_addr = '0; t_wr_data = '0;
        t_claim_en = 1'b0; t_claim_addr = '0;
        t_ra[0] = 5'd5; t_ra[1] = 5'd31; t_ra[2] = 5'd0;
        t_rst_n = 1'b0;
        @(posedge clock);
        model_edge();
        #1;

        // ---- Instance A: reset state and sweep ----
        step("a_reset");
        t_rst_n = 1'b1;
        t_wr_en = 1'b1; t_wr_addr = 5'd3; t_wr_data = 64'hA5A5_A5A5;
        t_claim_en = 1'b1; t_claim_addr = 5'd3;
        sweep("a_sweep", 31);
        step("a_post");
        t_ra[0] = 5'd3; t_ra[1] = 5'd5;
        #1; chk("a_r3_ignored", obs_data(0), 64'h0);
        step("a_r3");

        // Write r7 with same-cycle bypass, r0 on port 1.
        t_wr_en = 1'b1; t_wr_addr = 5'd7; t_wr_data = 64'hDEAD_BEEF;
        t_ra[0] = 5'd7; t_ra[1] = 5'd0;
        #1; chk("a_byp_r7", obs_data(0), 64'hDEAD_BEEF);
        step("a_wr7");
        clear_ctl();
        step("a_rd7");

        // r0 write and claim are ignored.
        t_wr_en = 1'b1; t_wr_addr = 5'd0; t_wr_data = 64'hFFFF_FFFF;
        t_claim_en = 1'b1; t_claim_addr = 5'd0;
        t_ra[0] = 5'd0; t_ra[1] = 5'd0;
        step("a_r0_wr");
        clear_ctl();
        step("a_r0_rd");

        // Claim r9, then writeback with bypass.
        t_claim_en = 1'b1; t_claim_addr = 5'd9;
        t_ra[0] = 5'd9; t_ra[1] = 5'd9;
        step("a_claim9");
        clear_ctl();
        #1; chk("a_busy9", 64'(a_busy), 64'h3);
        step("a_busy9");
        t_wr_en = 1'b1; t_wr_addr = 5'd9; t_wr_data = 64'h1234;
        #1; chk("a_wb9_data", obs_data(1), 64'h1234);
        step("a_wb9");
        clear_ctl();
        step("a_clr9");

        // Claim and write r4 in the same cycle: claim wins.
        t_wr_en = 1'b1; t_wr_addr = 5'd4; t_wr_data = 64'h55;
        t_claim_en = 1'b1; t_claim_addr = 5'd4;
        t_ra[0] = 5'd1; t_ra[1] = 5'd2;
        step("a_cw4");
        clear_ctl();
        t_ra[0] = 5'd4; t_ra[1] = 5'd4;
        #1; chk("a_cw4_busy", 64'(a_busy[0]), 64'h1);
        step("a_cw4_rd");

        rand_cycles("a_rand", 200);

        // Reset in the middle of a sweep with r9 pending.
        t_claim_en = 1'b1; t_claim_addr = 5'd9;
        step("a_pre_rst");
        clear_ctl();
        t_rst_n = 1'b0;
        step("a_rst2");
        t_rst_n = 1'b1;
        for (int i = 0; i < 11; i++) step("a_part");
        t_rst_n = 1'b0;
        step("a_rst3");
        t_rst_n = 1'b1;
        sweep("a_resweep", 31);
        t_ra[0] = 5'd9; t_ra[1] = 5'd9;
        #1; chk("a_r9_free", 64'(a_busy), 64'h0);
        step("a_r9");

        // ---- Instance B: 64-bit, 16 regs, 3 ports, no bypass ----
        sel = 1; cfg_nregs = 16; cfg_nread = 3; cfg_byp = 1'b0; cfg_xlen = 64;
        m_left = 15;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        clear_ctl();
        t_ra[0] = 5'd5; t_ra[1] = 5'd15; t_ra[2] = 5'd0;
        t_rst_n = 1'b0;
        step("b_reset");
        t_rst_n = 1'b1;
        sweep("b_sweep", 15);

        t_wr_en = 1'b1; t_wr_addr = 5'd7; t_wr_data = 64'hDEAD_BEEF;
        t_ra[0] = 5'd7; t_ra[1] = 5'd0; t_ra[2] = 5'd7;
        #1; chk("b_nobyp_old", obs_data(0), 64'h0);
        step("b_wr7");
        clear_ctl();
        #1; chk("b_nobyp_new", obs_data(0), 64'hDEAD_BEEF);
        step("b_rd7");

        t_wr_en = 1'b1; t_wr_addr = 5'd15; t_wr_data = 64'h0123_4567_89AB_CDEF;
        step("b_wr15");
        t_wr_addr = 5'd1; t_wr_data = 64'hFEDC_BA98_7654_3210;
        step("b_wr1");
        clear_ctl();
        t_ra[0] = 5'd15; t_ra[1] = 5'd15; t_ra[2] = 5'd1;
        #1;
        chk("b_p0_r15", obs_data(0), 64'h0123_4567_89AB_CDEF);
        chk("b_p2_r1", obs_data(2), 64'hFEDC_BA98_7654_3210);
        step("b_rd3");

        rand_cycles("b_rand", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
